// File: rtl/cfg_chain_loader.sv
// Host-side loader for the CGRA serial configuration chain: shifts parallel config words
// LSB-first into the chain and returns the displaced chain content as parallel readback words.
module cfg_chain_loader #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned NUM_TILES = 4,
  parameter int unsigned TILE_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              program_mode,
  output logic              chain_out,
  input  logic              chain_in,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NUM_WORDS = (NUM_TILES * TILE_BITS) / WORD_W;
  localparam int unsigned BIT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned WCNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_tx_sreg;
  logic [WORD_W-1:0]   r_rb_sreg;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [WCNT_W-1:0]   r_word_cnt;
  logic                r_cfg_ready;
  logic                r_program_mode;
  logic                r_chain_out;
  logic                r_rb_valid;
  logic [WORD_W-1:0]   r_rb_data;
  logic                r_busy;
  logic                r_done;
  logic [WORD_W-1:0]   w_rb_next;

  // Readback word as it stands once the current chain_in bit is captured
  assign w_rb_next = {chain_in, r_rb_sreg[WORD_W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_tx_sreg      <= '0;
      r_rb_sreg      <= '0;
      r_bit_cnt      <= '0;
      r_word_cnt     <= '0;
      r_cfg_ready    <= 1'b0;
      r_program_mode <= 1'b0;
      r_chain_out    <= 1'b0;
      r_rb_valid     <= 1'b0;
      r_rb_data      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_word_cnt  <= '0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          // Output registers are pre-set so program_mode/chain_out are valid from the first SHIFT cycle
          if (cfg_valid && r_cfg_ready) begin
            r_tx_sreg      <= cfg_data;
            r_bit_cnt      <= '0;
            r_cfg_ready    <= 1'b0;
            r_program_mode <= 1'b1;
            r_chain_out    <= cfg_data[0];
            r_state        <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_tx_sreg <= r_tx_sreg >> 1;
          r_rb_sreg <= w_rb_next;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            r_program_mode <= 1'b0;
            r_rb_data      <= w_rb_next;
            r_rb_valid     <= 1'b1;
            if (r_word_cnt == LAST_WORD) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_word_cnt  <= r_word_cnt + 1'b1;
              r_cfg_ready <= 1'b1;
              r_state     <= S_LOAD;
            end
          end else begin
            r_chain_out <= r_tx_sreg[1];
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready    = r_cfg_ready;
  assign program_mode = r_program_mode;
  assign chain_out    = r_chain_out;
  assign rb_valid     = r_rb_valid;
  assign rb_data      = r_rb_data;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
